// File: rtl/ets_phase_stepper.sv
`default_nettype none
// ============================================================================
//  Module      : ets_phase_stepper
//  Description : Walks the variable-phase DCM from its current fine-phase
//                position to an absolute target, one PSEN step at a time.
//                It tracks the position, settles after every completed step
//                and traps a PSDONE that never arrives.
//  Revision    : 1.0 - initial release
// ============================================================================
module ets_phase_stepper #(
    parameter int POS_WIDTH     = 8,
    parameter int MAX_POS       = 255,
    parameter int SETTLE_CYCLES = 16,
    parameter int DONE_TIMEOUT  = 255
) (
    input  logic                 ref_clk,
    input  logic                 reset,
    input  logic                 dcm_locked,
    input  logic [POS_WIDTH-1:0] target_delay,
    input  logic                 target_load,
    input  logic                 clear_fault,
    input  logic                 ps_done,
    output logic                 ps_en,
    output logic                 ps_incdec,
    output logic [POS_WIDTH-1:0] current_delay,
    output logic                 busy,
    output logic                 at_target,
    output logic                 fault
);

    // One counter serves both the settle wait and the PSDONE timeout, so it
    // is sized for whichever of the two is longer.
    localparam int c_CNT_MAX = (SETTLE_CYCLES > DONE_TIMEOUT) ? SETTLE_CYCLES : DONE_TIMEOUT;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [POS_WIDTH-1:0] c_MAX_POS     = POS_WIDTH'(MAX_POS);
    localparam logic [POS_WIDTH-1:0] c_POS_ONE     = POS_WIDTH'(1);
    localparam logic [c_CNT_W-1:0]   c_SETTLE_LAST = c_CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0]   c_DONE_LAST   = c_CNT_W'(DONE_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0]   c_CNT_ONE     = c_CNT_W'(1);

    localparam logic [2:0] c_ST_WAIT_LOCK = 3'd0;
    localparam logic [2:0] c_ST_IDLE      = 3'd1;
    localparam logic [2:0] c_ST_STEP      = 3'd2;
    localparam logic [2:0] c_ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] c_ST_SETTLE    = 3'd4;
    localparam logic [2:0] c_ST_FAULT     = 3'd5;

    logic [2:0]           r_state;
    logic [POS_WIDTH-1:0] r_target;
    logic [POS_WIDTH-1:0] r_current;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_incdec;
    logic                 r_busy;

    logic [2:0]           w_state_nxt;
    logic [POS_WIDTH-1:0] w_current_nxt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic                 w_incdec_nxt;
    logic [POS_WIDTH-1:0] w_target_clamped;

    // Requests beyond the last legal position are pinned to it.
    always_comb begin
        w_target_clamped = target_delay;
        if (target_delay > c_MAX_POS) begin
            w_target_clamped = c_MAX_POS;
        end
    end

    // Next-state, position, counter and direction decisions.
    always_comb begin
        w_state_nxt   = r_state;
        w_current_nxt = r_current;
        w_cnt_nxt     = r_cnt;
        w_incdec_nxt  = r_incdec;

        case (r_state)
            c_ST_WAIT_LOCK: begin
                // A fresh lock puts the DCM back at its calibrated origin.
                if (dcm_locked) begin
                    w_state_nxt   = c_ST_IDLE;
                    w_current_nxt = '0;
                end
            end

            c_ST_IDLE: begin
                if (!dcm_locked) begin
                    w_state_nxt = c_ST_WAIT_LOCK;
                end else if (r_current != r_target) begin
                    // Direction is latched here and held until PSDONE so a
                    // retarget cannot flip PSINCDEC under a step in flight.
                    w_state_nxt  = c_ST_STEP;
                    w_incdec_nxt = (r_target > r_current);
                end
            end

            c_ST_STEP: begin
                w_cnt_nxt = '0;
                if (!dcm_locked) begin
                    w_state_nxt = c_ST_WAIT_LOCK;
                end else begin
                    w_state_nxt = c_ST_WAIT_DONE;
                end
            end

            c_ST_WAIT_DONE: begin
                if (!dcm_locked) begin
                    // Step abandoned: the position is rebuilt from the origin
                    // on relock, so there is nothing to account for here.
                    w_state_nxt = c_ST_WAIT_LOCK;
                end else if (ps_done) begin
                    w_state_nxt = c_ST_SETTLE;
                    w_cnt_nxt   = '0;
                    if (r_incdec) begin
                        if (r_current != c_MAX_POS) begin
                            w_current_nxt = r_current + c_POS_ONE;
                        end
                    end else begin
                        if (r_current != '0) begin
                            w_current_nxt = r_current - c_POS_ONE;
                        end
                    end
                end else if (r_cnt == c_DONE_LAST) begin
                    w_state_nxt = c_ST_FAULT;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end

            c_ST_SETTLE: begin
                if (!dcm_locked) begin
                    w_state_nxt = c_ST_WAIT_LOCK;
                end else if (r_cnt == c_SETTLE_LAST) begin
                    w_state_nxt = c_ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end

            c_ST_FAULT: begin
                // Lock loss does not leave FAULT; only an explicit clear does.
                if (clear_fault) begin
                    w_state_nxt = c_ST_WAIT_LOCK;
                end
            end

            default: begin
                w_state_nxt = c_ST_WAIT_LOCK;
            end
        endcase
    end

    // State, position and target registers; reset overrides everything.
    always_ff @(posedge ref_clk) begin
        if (reset) begin
            r_state   <= c_ST_WAIT_LOCK;
            r_target  <= '0;
            r_current <= '0;
            r_cnt     <= '0;
            r_incdec  <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_current <= w_current_nxt;
            r_cnt     <= w_cnt_nxt;
            r_incdec  <= w_incdec_nxt;
            // Registered from the next state so busy reads 0 straight out of
            // reset and otherwise tracks "state is not IDLE" exactly.
            r_busy    <= (w_state_nxt != c_ST_IDLE);
            if (target_load) begin
                r_target <= w_target_clamped;
            end
        end
    end

    assign ps_en         = (r_state == c_ST_STEP);
    assign ps_incdec     = r_incdec;
    assign current_delay = r_current;
    assign busy          = r_busy;
    assign at_target     = (r_state == c_ST_IDLE) && dcm_locked && (r_current == r_target);
    assign fault         = (r_state == c_ST_FAULT);

endmodule
`default_nettype wire

// File: tb/tb_ets_phase_stepper.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ets_phase_stepper
//  Description : Directed bench for ets_phase_stepper with a PSDONE-echoing
//                DCM model and a queue of expected step directions.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ets_phase_stepper;

    localparam int c_POS_W   = 9;
    localparam int c_MAX_POS = 255;
    localparam int c_SETTLE  = 4;
    localparam int c_TIMEOUT = 20;
    localparam int c_DONE_LAT = 3;

    logic               ref_clk = 1'b0;
    logic               reset = 1'b1;
    logic               dcm_locked = 1'b0;
    logic [c_POS_W-1:0] target_delay = '0;
    logic               target_load = 1'b0;
    logic               clear_fault = 1'b0;
    logic               ps_done = 1'b0;
    logic               ps_en;
    logic               ps_incdec;
    logic [c_POS_W-1:0] current_delay;
    logic               busy;
    logic               at_target;
    logic               fault;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_en  = -1000;
    int en_count = 0;
    int done_cnt = 0;
    bit no_done  = 1'b0;
    bit prev_en  = 1'b0;
    bit en_dir   = 1'b0;
    bit q_dir[$];

    ets_phase_stepper #(
        .POS_WIDTH     (c_POS_W),
        .MAX_POS       (c_MAX_POS),
        .SETTLE_CYCLES (c_SETTLE),
        .DONE_TIMEOUT  (c_TIMEOUT)
    ) u_dut (
        .ref_clk       (ref_clk),
        .reset         (reset),
        .dcm_locked    (dcm_locked),
        .target_delay  (target_delay),
        .target_load   (target_load),
        .clear_fault   (clear_fault),
        .ps_done       (ps_done),
        .ps_en         (ps_en),
        .ps_incdec     (ps_incdec),
        .current_delay (current_delay),
        .busy          (busy),
        .at_target     (at_target),
        .fault         (fault)
    );

    always #5 ref_clk = ~ref_clk;

    always @(posedge ref_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // DCM model plus step scoreboard: echo PSDONE a fixed latency after each
    // PSEN and compare each step direction against the queued expectation.
    always @(negedge ref_clk) begin
        ps_done = 1'b0;
        if (done_cnt > 0) begin
            done_cnt--;
            if (done_cnt == 0 && !no_done) begin
                ps_done = 1'b1;
                if (dcm_locked && !reset) chk("incdec_hold", ps_incdec, en_dir);
            end
        end
        if (ps_en === 1'b1) begin
            chk("ps_en_single", prev_en, 0);
            chk("ps_en_locked", dcm_locked, 1);
            chk("ps_en_spacing", (cyc - last_en) >= (c_SETTLE + 2), 1);
            chk("step_expected", q_dir.size() > 0, 1);
            if (q_dir.size() > 0) chk("ps_incdec", ps_incdec, q_dir.pop_front());
            last_en  = cyc;
            en_count++;
            done_cnt = c_DONE_LAT;
            en_dir   = ps_incdec;
        end
        prev_en = (ps_en === 1'b1);
    end

    task automatic push_steps(input int n, input bit dir);
        for (int i = 0; i < n; i++) q_dir.push_back(dir);
    endtask

    task automatic load_target(input int v);
        target_delay = c_POS_W'(v);
        target_load  = 1'b1;
        @(negedge ref_clk);
        target_load  = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int bound);
        bit ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge ref_clk);
            if (at_target === 1'b1 && busy === 1'b0) ok = 1'b1;
        end
        chk(tag, ok, 1);
    endtask

    task automatic wait_en(input string tag, input int bound);
        bit ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge ref_clk);
            if (ps_en === 1'b1) ok = 1'b1;
        end
        chk(tag, ok, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        // Reset state
        repeat (3) @(negedge ref_clk);
        chk("rst_ps_en", ps_en, 0);
        chk("rst_incdec", ps_incdec, 0);
        chk("rst_current", current_delay, 0);
        chk("rst_busy", busy, 0);
        chk("rst_at_target", at_target, 0);
        chk("rst_fault", fault, 0);
        reset = 1'b0;
        dcm_locked = 1'b1;
        repeat (3) @(negedge ref_clk);
        chk("lock_at_target", at_target, 1);
        chk("lock_busy", busy, 0);

        // 1: walk up 0 -> 5
        base = en_count;
        push_steps(5, 1'b1);
        load_target(5);
        wait_idle("t1_idle", 400);
        chk("t1_current", current_delay, 5);
        chk("t1_pulses", en_count - base, 5);
        chk("t1_queue", q_dir.size(), 0);

        // 2: walk down 5 -> 2
        base = en_count;
        push_steps(3, 1'b0);
        load_target(2);
        wait_idle("t2_idle", 400);
        chk("t2_current", current_delay, 2);
        chk("t2_pulses", en_count - base, 3);

        // 3: retarget while the 4 -> 5 step is in flight
        push_steps(3, 1'b1);
        load_target(10);
        base = 0;
        for (int i = 0; i < 400 && base == 0; i++) begin
            @(negedge ref_clk);
            if (ps_en === 1'b1 && current_delay == 4) base = 1;
        end
        chk("t3_reach4", base, 1);
        push_steps(4, 1'b0);
        load_target(1);
        wait_idle("t3_idle", 600);
        chk("t3_current", current_delay, 1);
        chk("t3_queue", q_dir.size(), 0);

        // 2b: oversize target clamps to MAX_POS
        push_steps(254, 1'b1);
        load_target(300);
        wait_idle("t2b_idle", 5000);
        chk("t2b_current", current_delay, 255);

        // 4: PSDONE never arrives
        no_done = 1'b1;
        push_steps(1, 1'b0);
        load_target(250);
        wait_en("t4_en", 100);
        repeat (c_TIMEOUT) @(negedge ref_clk);
        chk("t4_fault_early", fault, 0);
        @(negedge ref_clk);
        chk("t4_fault", fault, 1);
        chk("t4_current", current_delay, 255);
        chk("t4_busy", busy, 1);
        no_done = 1'b0;
        repeat (5) @(negedge ref_clk);
        chk("t4_fault_sticky", fault, 1);
        push_steps(250, 1'b1);
        clear_fault = 1'b1;
        @(negedge ref_clk);
        clear_fault = 1'b0;
        chk("t4_cleared", fault, 0);
        @(negedge ref_clk);
        chk("t4_origin", current_delay, 0);
        wait_idle("t4_idle", 5000);
        chk("t4_resumed", current_delay, 250);

        // 5: lock lost while waiting for PSDONE
        push_steps(3, 1'b1);
        load_target(253);
        wait_en("t5_en", 100);
        @(negedge ref_clk);
        dcm_locked = 1'b0;
        q_dir.delete();
        repeat (10) @(negedge ref_clk);
        chk("t5_busy", busy, 1);
        chk("t5_at_target", at_target, 0);
        chk("t5_current_held", current_delay, 250);
        push_steps(253, 1'b1);
        dcm_locked = 1'b1;
        @(negedge ref_clk);
        chk("t5_relock_origin", current_delay, 0);
        wait_idle("t5_idle", 5000);
        chk("t5_current", current_delay, 253);

        // 6: reset mid-step
        push_steps(1, 1'b0);
        load_target(100);
        wait_en("t6_en", 100);
        reset = 1'b1;
        @(negedge ref_clk);
        chk("t6_ps_en", ps_en, 0);
        chk("t6_incdec", ps_incdec, 0);
        chk("t6_current", current_delay, 0);
        chk("t6_busy", busy, 0);
        chk("t6_at_target", at_target, 0);
        chk("t6_fault", fault, 0);
        @(negedge ref_clk);
        reset = 1'b0;
        repeat (3) @(negedge ref_clk);
        chk("t6_target_zero", at_target, 1);
        chk("t6_idle_busy", busy, 0);
        repeat (30) @(negedge ref_clk);
        chk("t6_no_steps", current_delay, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
